// File: rtl/rsnn_neuron_sequencer.sv
// Run-time controller for one recurrent spiking neuron: config registers, timestep prescaler, windowed spike counter.
// Optional RSNN_SEQ_ONESHOT_EN: stop after the first completed window and require a fresh rising edge on run.
module rsnn_neuron_sequencer #(
  parameter logic [7:0] DEF_THRESHOLD  = 8'd64,
  parameter logic [7:0] DEF_DECAY      = 8'd1,
  parameter logic [7:0] DEF_REFRACTORY = 8'd2,
  parameter logic [7:0] DEF_WINDOW     = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       run,
  input  logic       spike_in,
  output logic       neuron_enable,
  output logic       neuron_clear,
  output logic [7:0] threshold,
  output logic [7:0] decay,
  output logic [7:0] refractory_period,
  output logic [7:0] feedback_scale,
  output logic [7:0] spike_count,
  output logic       count_valid,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state, state_next;
  logic [7:0] tick_div, window_len;
  logic [7:0] pre, pre_n;
  logic [7:0] acc, acc_inc;
  logic [7:0] win_cnt;
  logic       en_d;
  logic       start, sample, win_done;
`ifdef RSNN_SEQ_ONESHOT_EN
  logic       run_d;
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and datapath decode
  always_comb begin
    state_next = state;
`ifdef RSNN_SEQ_ONESHOT_EN
    start      = run && !run_d;
`else
    start      = run;
`endif
    sample     = (state == RUN) && en_d;
    acc_inc    = (spike_in && (acc != 8'hFF)) ? acc + 8'd1 : acc;
    // window_len of 0 wraps to 255 here, giving a 256-enable window
    win_done   = sample && (win_cnt == 8'(window_len - 8'd1));
    pre_n      = neuron_enable ? 8'd0 : pre + 8'd1;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (!run) state_next = IDLE;
`ifdef RSNN_SEQ_ONESHOT_EN
        else if (win_done) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Configuration registers; writes are only accepted while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold         <= DEF_THRESHOLD;
      decay             <= DEF_DECAY;
      refractory_period <= DEF_REFRACTORY;
      feedback_scale    <= 8'd0;
      tick_div          <= 8'd0;
      window_len        <= DEF_WINDOW;
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        3'd0:    threshold         <= cfg_data;
        3'd1:    decay             <= cfg_data;
        3'd2:    refractory_period <= cfg_data;
        3'd3:    feedback_scale    <= cfg_data;
        3'd4:    tick_div          <= cfg_data;
        3'd5:    window_len        <= cfg_data;
        default: ;
      endcase
    end
  end

  // Prescaler, tick generation and window accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre           <= 8'd0;
      acc           <= 8'd0;
      win_cnt       <= 8'd0;
      en_d          <= 1'b0;
      neuron_enable <= 1'b0;
      neuron_clear  <= 1'b0;
      spike_count   <= 8'd0;
      count_valid   <= 1'b0;
    end else begin
      en_d         <= neuron_enable;
      count_valid  <= 1'b0;
      neuron_clear <= 1'b0;
      if (state == IDLE) begin
        pre           <= 8'd0;
        acc           <= 8'd0;
        win_cnt       <= 8'd0;
        neuron_enable <= 1'b0;
        if (start) neuron_clear <= 1'b1;
      end else begin
        if (win_done) begin
          spike_count <= acc_inc;
          count_valid <= 1'b1;
          acc         <= 8'd0;
          win_cnt     <= 8'd0;
        end else if (sample) begin
          acc     <= acc_inc;
          win_cnt <= win_cnt + 8'd1;
        end
        // neuron_clear marks the first RUN cycle, where the prescaler holds
        if (state_next != RUN) begin
          neuron_enable <= 1'b0;
        end else if (neuron_clear) begin
          neuron_enable <= (pre == tick_div);
        end else begin
          pre           <= pre_n;
          neuron_enable <= (pre_n == tick_div);
        end
      end
    end
  end

`ifdef RSNN_SEQ_ONESHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_d <= 1'b0;
    else        run_d <= run;
  end
`endif

endmodule

// File: tb/tb_rsnn_neuron_sequencer.sv
// Directed self-checking bench for rsnn_neuron_sequencer.
module tb_rsnn_neuron_sequencer;

`ifdef RSNN_SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       run;
  logic       spike_in;
  logic       neuron_enable;
  logic       neuron_clear;
  logic [7:0] threshold;
  logic [7:0] decay;
  logic [7:0] refractory_period;
  logic [7:0] feedback_scale;
  logic [7:0] spike_count;
  logic       count_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int k;
  int cvs;

  always #5 clk = ~clk;

  rsnn_neuron_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run(run), .spike_in(spike_in),
    .neuron_enable(neuron_enable), .neuron_clear(neuron_clear),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .feedback_scale(feedback_scale),
    .spike_count(spike_count), .count_valid(count_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
    run = 1'b0; spike_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_threshold", 32'(threshold), 32'd64);
    check("rst_decay", 32'(decay), 32'd1);
    check("rst_refractory", 32'(refractory_period), 32'd2);
    check("rst_feedback", 32'(feedback_scale), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spike_count", 32'(spike_count), 32'd0);
    check("rst_count_valid", 32'(count_valid), 32'd0);
    check("rst_enable", 32'(neuron_enable), 32'd0);
    check("rst_clear", 32'(neuron_clear), 32'd0);

    // Threshold write, then tick_div=3 written together with run
    cfg_write(3'd0, 8'h30);
    check("wr_threshold", 32'(threshold), 32'h30);
    cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd3; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    k = 1;
    check("run1_clear", 32'(neuron_clear), 32'd1);
    check("run1_enable", 32'(neuron_enable), 32'd0);
    check("run1_busy", 32'(busy), 32'd1);
    check("run1_cfg_ready", 32'(cfg_ready), 32'd0);
    for (int i = 2; i <= 14; i++) begin
      step();
      k = i;
      check($sformatf("td3_enable_c%0d", k), 32'(neuron_enable),
            32'((k == 5) || (k == 9) || (k == 13)));
      check($sformatf("td3_clear_c%0d", k), 32'(neuron_clear), 32'd0);
    end
    run = 1'b0;
    step();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_enable", 32'(neuron_enable), 32'd0);

    // window_len=4, tick_div=0, spike_in high
    cfg_write(3'd5, 8'd4);
    spike_in = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd0; run = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      step();
      k = i;
      check($sformatf("w4_enable_c%0d", k), 32'(neuron_enable),
            32'((k >= 2) && (!ONESHOT || k <= 6)));
      check($sformatf("w4_count_valid_c%0d", k), 32'(count_valid),
            32'((k == 7) || (!ONESHOT && k > 7 && ((k - 7) % 4 == 0))));
      if (count_valid) check($sformatf("w4_spike_count_c%0d", k), 32'(spike_count), 32'd4);
    end

`ifndef RSNN_SEQ_ONESHOT_EN
    // Config request held during RUN stalls, then lands once idle
    cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h55;
    step();
    check("stall_ready", 32'(cfg_ready), 32'd0);
    check("stall_decay_a", 32'(decay), 32'd1);
    step();
    check("stall_decay_b", 32'(decay), 32'd1);
    run = 1'b0;
    step();
    check("stall_idle_busy", 32'(busy), 32'd0);
    check("stall_idle_ready", 32'(cfg_ready), 32'd1);
    check("stall_idle_decay", 32'(decay), 32'd1);
    check("stall_idle_cv", 32'(count_valid), 32'd0);
    step();
    cfg_valid = 1'b0;
    check("stall_landed_decay", 32'(decay), 32'h55);
    check("stall_spike_count", 32'(spike_count), 32'd4);
`else
    run = 1'b0;
    step();
`endif

    // window_len=0 (256 enables) saturates the count at 255
    cfg_write(3'd5, 8'd0);
    run = 1'b1;
    step();
    k = 1;
    for (int i = 0; i < 400 && !count_valid; i++) begin
      step();
      k++;
    end
    check("sat_cv_cycle", 32'(k), 32'd259);
    check("sat_count_valid", 32'(count_valid), 32'd1);
    check("sat_spike_count", 32'(spike_count), 32'd255);

    // Drop run mid-window: partial window discarded
    cvs = 0;
    repeat (50) begin step(); if (count_valid) cvs++; end
    run = 1'b0;
    repeat (4) begin step(); if (count_valid) cvs++; end
    check("partial_no_cv", 32'(cvs), 32'd0);
    check("partial_spike_count", 32'(spike_count), 32'd255);
    check("partial_busy", 32'(busy), 32'd0);

    // run low exactly on the final sample cycle still completes the window
    cfg_write(3'd5, 8'd4);
    run = 1'b1;
    step();
    repeat (5) step();
    run = 1'b0;
    step();
    check("edge_stop_cv", 32'(count_valid), 32'd1);
    check("edge_stop_count", 32'(spike_count), 32'd4);
    check("edge_stop_busy", 32'(busy), 32'd0);
    step();
    check("edge_stop_cv_after", 32'(count_valid), 32'd0);
    check("edge_stop_enable", 32'(neuron_enable), 32'd0);

`ifdef RSNN_SEQ_ONESHOT_EN
    // One-shot: run held high gives exactly one window
    run = 1'b1;
    step();
    cvs = 0;
    repeat (20) begin step(); if (count_valid) cvs++; end
    check("oneshot_cv_count", 32'(cvs), 32'd1);
    check("oneshot_busy", 32'(busy), 32'd0);
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    check("oneshot_rearm_busy", 32'(busy), 32'd1);
    check("oneshot_rearm_clear", 32'(neuron_clear), 32'd1);
    for (int i = 0; i < 20 && !count_valid; i++) step();
    check("oneshot_second_cv", 32'(count_valid), 32'd1);
    run = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
